// File: rtl/patch_kp_reader.sv
// Per-patch keypoint table: captures patch writes during a frame, then streams
// the qualifying entries out in ascending ID order and clears the table.
module patch_kp_reader #(
    parameter int NUM_PATCH = 100,
    parameter int MIN_SCORE = 1
) (
    input  logic        clk,
    input  logic        en,
    input  logic        wr_en,
    input  logic [6:0]  wr_id,
    input  logic [14:0] wr_score,
    input  logic [7:0]  wr_row,
    input  logic [8:0]  wr_col,
    input  logic        frame_end,
    output logic        kp_valid,
    input  logic        kp_ready,
    output logic [6:0]  kp_id,
    output logic [14:0] kp_score,
    output logic [7:0]  kp_row,
    output logic [8:0]  kp_col,
    output logic        scan_done,
    output logic [7:0]  kp_count,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_EMIT    = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    localparam logic [7:0]  NUM_PATCH_W = 8'(NUM_PATCH);
    localparam logic [6:0]  LAST_ID     = 7'(NUM_PATCH - 1);
    localparam logic [14:0] MIN_SC      = 15'(MIN_SCORE);

    state_t                 state_r;
    logic [6:0]             ptr_r;
    logic [7:0]             count_r;
    logic [NUM_PATCH-1:0]   valid_r;

    logic [14:0] score_mem [NUM_PATCH];
    logic [7:0]  row_mem   [NUM_PATCH];
    logic [8:0]  col_mem   [NUM_PATCH];

    logic        wr_accept_s;
    logic        wr_drop_s;
    logic [14:0] rd_score_s;
    logic [7:0]  rd_row_s;
    logic [8:0]  rd_col_s;
    logic        rd_ok_s;
    logic        last_s;

    // An entry is emitted only if it was written this frame and scores high enough
    function automatic logic entry_qualifies(input logic v, input logic [14:0] s);
        return v && (s >= MIN_SC);
    endfunction

    // Write acceptance and drop qualification
    always_comb begin
        wr_accept_s = wr_en && (state_r == ST_COLLECT) && ({1'b0, wr_id} < NUM_PATCH_W);
        wr_drop_s   = wr_en && (state_r != ST_COLLECT);
    end

    // Entry payload storage; contents are meaningless unless the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            score_mem[wr_id] <= wr_score;
            row_mem[wr_id]   <= wr_row;
            col_mem[wr_id]   <= wr_col;
        end
    end

    // Table read at the scan pointer
    always_comb begin
        rd_score_s = score_mem[ptr_r];
        rd_row_s   = row_mem[ptr_r];
        rd_col_s   = col_mem[ptr_r];
        rd_ok_s    = entry_qualifies(valid_r[ptr_r], rd_score_s);
        last_s     = (ptr_r == LAST_ID);
    end

    // Drop counter, saturating at its maximum
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            drop_cnt <= 8'd0;
        end else if (wr_drop_s && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Collect / scan / emit / clear sequencer with registered outputs
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_r   <= ST_COLLECT;
            ptr_r     <= 7'd0;
            count_r   <= 8'd0;
            valid_r   <= '0;
            kp_valid  <= 1'b0;
            kp_id     <= 7'd0;
            kp_score  <= 15'd0;
            kp_row    <= 8'd0;
            kp_col    <= 9'd0;
            scan_done <= 1'b0;
            kp_count  <= 8'd0;
            busy      <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            kp_count  <= 8'd0;
            if (wr_accept_s) begin
                valid_r[wr_id] <= 1'b1;
            end
            case (state_r)
                ST_COLLECT: begin
                    if (frame_end) begin
                        state_r <= ST_SCAN;
                        ptr_r   <= 7'd0;
                        count_r <= 8'd0;
                        busy    <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (rd_ok_s) begin
                        kp_id    <= ptr_r;
                        kp_score <= rd_score_s;
                        kp_row   <= rd_row_s;
                        kp_col   <= rd_col_s;
                        kp_valid <= 1'b1;
                        state_r  <= ST_EMIT;
                    end else if (last_s) begin
                        state_r   <= ST_CLEAR;
                        scan_done <= 1'b1;
                        kp_count  <= count_r;
                    end else begin
                        ptr_r <= ptr_r + 7'd1;
                    end
                end
                ST_EMIT: begin
                    if (kp_ready) begin
                        kp_valid <= 1'b0;
                        count_r  <= count_r + 8'd1;
                        if (last_s) begin
                            state_r   <= ST_CLEAR;
                            scan_done <= 1'b1;
                            kp_count  <= count_r + 8'd1;
                        end else begin
                            ptr_r   <= ptr_r + 7'd1;
                            state_r <= ST_SCAN;
                        end
                    end
                end
                ST_CLEAR: begin
                    valid_r <= '0;
                    state_r <= ST_COLLECT;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_COLLECT;
                    kp_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_patch_kp_reader.sv
// Scoreboard bench for patch_kp_reader: stimulus pushes expected keypoints and
// frame counts; an independent monitor pops and compares on every handshake.
module tb_patch_kp_reader;

    logic        clk = 1'b0;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_id = 7'd0;
    logic [14:0] wr_score = 15'd0;
    logic [7:0]  wr_row = 8'd0;
    logic [8:0]  wr_col = 9'd0;
    logic        frame_end = 1'b0;
    logic        kp_valid;
    logic        kp_ready = 1'b1;
    logic [6:0]  kp_id;
    logic [14:0] kp_score;
    logic [7:0]  kp_row;
    logic [8:0]  kp_col;
    logic        scan_done;
    logic [7:0]  kp_count;
    logic        busy;
    logic [7:0]  drop_cnt;

    typedef struct {
        int id;
        int score;
        int row;
        int col;
    } kp_t;

    kp_t exp_q[$];
    int  cnt_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    patch_kp_reader #(.NUM_PATCH(100), .MIN_SCORE(1)) dut (
        .clk(clk), .en(en), .wr_en(wr_en), .wr_id(wr_id), .wr_score(wr_score),
        .wr_row(wr_row), .wr_col(wr_col), .frame_end(frame_end),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_id(kp_id),
        .kp_score(kp_score), .kp_row(kp_row), .kp_col(kp_col),
        .scan_done(scan_done), .kp_count(kp_count), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compares on the falling edge, when the next rising edge completes a transfer
    always @(negedge clk) begin
        if (en) begin
            if (kp_valid && kp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_kp_id", int'(kp_id), -1);
                end else begin
                    kp_t e;
                    e = exp_q.pop_front();
                    chk("kp_id", int'(kp_id), e.id);
                    chk("kp_score", int'(kp_score), e.score);
                    chk("kp_row", int'(kp_row), e.row);
                    chk("kp_col", int'(kp_col), e.col);
                end
            end
            if (scan_done) begin
                if (cnt_q.size() == 0) begin
                    chk("unexpected_scan_done", int'(kp_count), -1);
                end else begin
                    chk("kp_count", int'(kp_count), cnt_q.pop_front());
                end
            end
        end
    end

    task automatic expect_kp(input int id, input int s, input int r, input int c);
        kp_t e;
        e.id = id; e.score = s; e.row = r; e.col = c;
        exp_q.push_back(e);
    endtask

    task automatic wr(input int id, input int s, input int r, input int c, input logic fe);
        wr_en = 1'b1;
        wr_id = 7'(id);
        wr_score = 15'(s);
        wr_row = 8'(r);
        wr_col = 9'(c);
        frame_end = fe;
        @(posedge clk); #1;
        wr_en = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk(nm, 1, 0);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!kp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, int'(kp_valid), 1);
    endtask

    initial begin
        int cap_id;
        int cap_score;
        int n;

        // Reset state
        #2;
        chk("rst_kp_valid", int'(kp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_scan_done", int'(scan_done), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_kp_count", int'(kp_count), 0);
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;

        // 1: two entries emitted in ID order
        wr(3, 50, 10, 20, 1'b0);
        wr(7, 9, 30, 40, 1'b0);
        expect_kp(3, 50, 10, 20);
        expect_kp(7, 9, 30, 40);
        cnt_q.push_back(2);
        pulse_fe();
        chk("t1_busy", int'(busy), 1);
        wait_idle("t1_timeout");

        // 2: last write wins; last ID emits and finishes the scan
        wr(5, 10, 1, 2, 1'b0);
        wr(5, 4, 12, 13, 1'b0);
        wr(99, 32767, 239, 375, 1'b0);
        expect_kp(5, 4, 12, 13);
        expect_kp(99, 32767, 239, 375);
        cnt_q.push_back(2);
        pulse_fe();
        wait_idle("t2_timeout");

        // 3: downstream stall holds output stable
        wr(1, 100, 5, 6, 1'b0);
        wr(4, 200, 7, 8, 1'b0);
        expect_kp(1, 100, 5, 6);
        expect_kp(4, 200, 7, 8);
        cnt_q.push_back(2);
        kp_ready = 1'b0;
        pulse_fe();
        wait_valid("t3_valid_seen");
        cap_id = int'(kp_id);
        cap_score = int'(kp_score);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_valid", int'(kp_valid), 1);
            chk("t3_hold_id", int'(kp_id), cap_id);
            chk("t3_hold_score", int'(kp_score), cap_score);
        end
        kp_ready = 1'b1;
        wait_idle("t3_timeout");

        // 4: write with frame_end included; out-of-range and zero-score not emitted
        wr(120, 77, 1, 1, 1'b0);
        wr(9, 0, 2, 2, 1'b0);
        expect_kp(2, 33, 44, 55);
        cnt_q.push_back(1);
        wr(2, 33, 44, 55, 1'b1);
        wait_idle("t4_timeout");

        // 5: writes while busy are dropped; frame_end while busy ignored
        wr(10, 60, 3, 4, 1'b0);
        expect_kp(10, 60, 3, 4);
        cnt_q.push_back(1);
        pulse_fe();
        wr(11, 70, 1, 1, 1'b0);
        wr(11, 70, 1, 1, 1'b0);
        wr(11, 70, 1, 1, 1'b0);
        wait_idle("t5_timeout");
        chk("t5_drop_cnt", int'(drop_cnt), 3);
        cnt_q.push_back(0);
        pulse_fe();
        repeat (5) begin @(posedge clk); #1; end
        pulse_fe();
        wait_idle("t5b_timeout");
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_fe_ignored_busy", int'(busy), 0);

        // 6: reset during EMIT aborts immediately
        wr(1, 5, 1, 1, 1'b0);
        wr(2, 6, 2, 2, 1'b0);
        kp_ready = 1'b0;
        pulse_fe();
        wait_valid("t6_valid_seen");
        en = 1'b0;
        #1;
        chk("t6_abort_valid", int'(kp_valid), 0);
        chk("t6_abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        en = 1'b1;
        kp_ready = 1'b1;
        cnt_q.push_back(0);
        pulse_fe();
        wait_idle("t6_timeout");

        // Drop counter saturation across several empty frames
        for (int f = 0; f < 3; f++) begin
            cnt_q.push_back(0);
            pulse_fe();
            n = 0;
            while (busy && n < 400) begin
                wr_en = 1'b1;
                wr_id = 7'd0;
                @(posedge clk); #1;
                n++;
            end
            wr_en = 1'b0;
        end
        chk("drop_cnt_sat", int'(drop_cnt), 255);

        repeat (5) begin @(posedge clk); #1; end
        chk("kp_queue_drained", exp_q.size(), 0);
        chk("cnt_queue_drained", cnt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
